// File: rtl/bit_counter_arbiter.sv
// ============================================================================
// Module   : bit_counter_arbiter
// Brief    : Round-robin arbiter sharing one chunked, pipelined popcount
//            datapath between REQ_NUM requesters. Optional per-requester
//            grant statistics are built when BIT_COUNTER_ARB_STATS_EN is set.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bit_counter_arbiter #(
    parameter int REQ_NUM = 4,
    parameter int WIDTH   = 16,
    parameter int STAGES  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         arb_en_i,
    input  logic [REQ_NUM*WIDTH-1:0]     req_data_i,
    input  logic [REQ_NUM-1:0]           req_valid_i,
    output logic [REQ_NUM-1:0]           req_ready_o,
    output logic [$clog2(WIDTH):0]       res_count_o,
    output logic [$clog2(REQ_NUM)-1:0]   res_id_o,
    output logic [REQ_NUM-1:0]           res_val_o,
    output logic                         busy_o
`ifdef BIT_COUNTER_ARB_STATS_EN
    ,
    input  logic                         stats_clr_i,
    output logic [REQ_NUM*16-1:0]        grant_cnt_o
`endif
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;
    localparam int c_idw   = $clog2(REQ_NUM);
    localparam int c_chunk = WIDTH / STAGES;

    function automatic logic [c_cnt_w-1:0] f_popcnt(input logic [c_chunk-1:0] v);
        logic [c_cnt_w-1:0] sum;
        sum = '0;
        for (int i = 0; i < c_chunk; i++) begin
            sum = sum + c_cnt_w'(v[i]);
        end
        return sum;
    endfunction

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    logic [c_idw-1:0] r_ptr;
    logic [c_idw-1:0] w_grant_idx;
    logic [c_idw-1:0] w_cand;
    logic             w_grant_found;
    logic             w_accept;

    always_comb begin
        int v_idx;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        v_idx         = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            v_idx  = (int'(r_ptr) + i) % REQ_NUM;
            w_cand = c_idw'(v_idx);
            if (!w_grant_found && req_valid_i[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // No grant is issued while reset is held, so nothing is accepted then.
    assign w_accept    = arb_en_i & rst_n_i & w_grant_found;
    assign req_ready_o = w_accept ? (REQ_NUM'(1) << w_grant_idx) : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_grant_idx == c_idw'(REQ_NUM - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Popcount pipeline
    // ------------------------------------------------------------------
    logic [STAGES-1:0]  r_valid;
    logic [WIDTH-1:0]   r_data [STAGES];
    logic [c_cnt_w-1:0] r_cnt  [STAGES];
    logic [c_idw-1:0]   r_id   [STAGES];

    logic [STAGES-1:0]  w_in_valid;
    logic [WIDTH-1:0]   w_in_data [STAGES];
    logic [c_cnt_w-1:0] w_in_cnt  [STAGES];
    logic [c_idw-1:0]   w_in_id   [STAGES];
    logic [c_cnt_w-1:0] w_sum     [STAGES];
    logic               w_busy_nxt;

    always_comb begin
        w_in_valid[0] = w_accept;
        w_in_data[0]  = req_data_i[w_grant_idx*WIDTH +: WIDTH];
        w_in_cnt[0]   = '0;
        w_in_id[0]    = w_grant_idx;
        for (int s = 1; s < STAGES; s++) begin
            w_in_valid[s] = r_valid[s-1];
            w_in_data[s]  = r_data[s-1];
            w_in_cnt[s]   = r_cnt[s-1];
            w_in_id[s]    = r_id[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            w_sum[s] = w_in_cnt[s] + f_popcnt(w_in_data[s][s*c_chunk +: c_chunk]);
        end
    end

    // Next-cycle occupancy of the stages, so busy_o tracks r_valid exactly.
    always_comb begin
        w_busy_nxt = w_accept;
        for (int s = 0; s < STAGES - 1; s++) begin
            w_busy_nxt = w_busy_nxt | r_valid[s];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_in_valid;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < STAGES; s++) begin
            r_data[s] <= w_in_data[s];
            r_cnt[s]  <= w_sum[s];
            r_id[s]   <= w_in_id[s];
        end
    end

    // ------------------------------------------------------------------
    // Result register
    // ------------------------------------------------------------------
    logic [REQ_NUM-1:0] r_res_val;
    logic [c_cnt_w-1:0] r_res_cnt;
    logic [c_idw-1:0]   r_res_id;
    logic               r_busy;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_res_val <= '0;
            r_res_cnt <= '0;
            r_res_id  <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (r_valid[STAGES-1]) begin
                r_res_val <= REQ_NUM'(1) << r_id[STAGES-1];
                r_res_cnt <= r_cnt[STAGES-1];
                r_res_id  <= r_id[STAGES-1];
            end else begin
                r_res_val <= '0;
                r_res_cnt <= '0;
                r_res_id  <= '0;
            end
        end
    end

    assign res_val_o   = r_res_val;
    assign res_count_o = r_res_cnt;
    assign res_id_o    = r_res_id;
    assign busy_o      = r_busy;

`ifdef BIT_COUNTER_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating per-requester grant counters
    // ------------------------------------------------------------------
    for (genvar k = 0; k < REQ_NUM; k++) begin : g_stats
        logic [15:0] r_grant_cnt;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_grant_cnt <= '0;
            end else if (stats_clr_i) begin
                r_grant_cnt <= '0;
            end else if (req_valid_i[k] && req_ready_o[k] && (r_grant_cnt != 16'hFFFF)) begin
                r_grant_cnt <= r_grant_cnt + 16'd1;
            end
        end

        assign grant_cnt_o[k*16 +: 16] = r_grant_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bit_counter_arbiter.sv
// ============================================================================
// Module   : tb_bit_counter_arbiter
// Brief    : Randomised self-checking bench for bit_counter_arbiter against a
//            transaction-level reference model (pointer, hold flags, delay queue).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bit_counter_arbiter;

    localparam int REQ_NUM = 4;
    localparam int WIDTH   = 16;
    localparam int STAGES  = 4;

    logic                       clk_i = 1'b0;
    logic                       rst_n_i;
    logic                       arb_en_i;
    logic [REQ_NUM*WIDTH-1:0]   req_data_i;
    logic [REQ_NUM-1:0]         req_valid_i;
    logic [REQ_NUM-1:0]         req_ready_o;
    logic [$clog2(WIDTH):0]     res_count_o;
    logic [$clog2(REQ_NUM)-1:0] res_id_o;
    logic [REQ_NUM-1:0]         res_val_o;
    logic                       busy_o;
`ifdef BIT_COUNTER_ARB_STATS_EN
    logic                       stats_clr_i;
    logic [REQ_NUM*16-1:0]      grant_cnt_o;
`endif

    bit_counter_arbiter #(
        .REQ_NUM (REQ_NUM),
        .WIDTH   (WIDTH),
        .STAGES  (STAGES)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .arb_en_i    (arb_en_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .res_count_o (res_count_o),
        .res_id_o    (res_id_o),
        .res_val_o   (res_val_o),
        .busy_o      (busy_o)
`ifdef BIT_COUNTER_ARB_STATS_EN
        ,
        .stats_clr_i (stats_clr_i),
        .grant_cnt_o (grant_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a result is the popcount of the accepted word, emerging
    // STAGES+1 negedges after the negedge on which its grant was decided.
    typedef struct {
        bit v;
        int id;
        int cnt;
    } res_t;

    res_t        pipe_q[$];
    int          ptr;
    bit          holding  [REQ_NUM];
    logic [15:0] hold_data[REQ_NUM];

    function automatic logic [15:0] pick_data();
        logic [15:0] tbl [5];
        tbl[0] = 16'h0000; tbl[1] = 16'h8001; tbl[2] = 16'hAAAA;
        tbl[3] = 16'h0F0F; tbl[4] = 16'hFFFF;
        if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    task automatic check_outputs();
        res_t e;
        bit   busy_exp;
        e.v = 1'b0; e.id = 0; e.cnt = 0;
        if (pipe_q.size() == STAGES + 1) e = pipe_q.pop_front();
        busy_exp = 1'b0;
        foreach (pipe_q[i]) busy_exp = busy_exp | pipe_q[i].v;
        check_eq("res_val",   32'(res_val_o),   e.v ? (32'd1 << e.id) : 32'd0);
        check_eq("res_id",    32'(res_id_o),    e.v ? 32'(e.id)  : 32'd0);
        check_eq("res_count", 32'(res_count_o), e.v ? 32'(e.cnt) : 32'd0);
        check_eq("busy",      32'(busy_o),      32'(busy_exp));
    endtask

    task automatic run_cycles(input int n, input int prob, input logic [3:0] mask, input int en_pct);
        for (int c = 0; c < n; c++) begin
            res_t p;
            int   g;
            @(negedge clk_i);
            check_outputs();
            for (int k = 0; k < REQ_NUM; k++) begin
                if (!holding[k] && mask[k] && ($urandom_range(0, 99) < prob)) begin
                    holding[k]   = 1'b1;
                    hold_data[k] = pick_data();
                end
                req_valid_i[k]           = holding[k];
                req_data_i[k*WIDTH +: WIDTH] = hold_data[k];
            end
            arb_en_i = ($urandom_range(0, 99) < en_pct);
            #1;
            g = -1;
            if (arb_en_i) begin
                for (int off = 0; off < REQ_NUM; off++) begin
                    if (g < 0 && holding[(ptr + off) % REQ_NUM]) g = (ptr + off) % REQ_NUM;
                end
            end
            check_eq("req_ready", 32'(req_ready_o), (g >= 0) ? (32'd1 << g) : 32'd0);
            p.v   = (g >= 0);
            p.id  = (g >= 0) ? g : 0;
            p.cnt = (g >= 0) ? $countones(hold_data[g]) : 0;
            pipe_q.push_back(p);
            if (g >= 0) begin
                holding[g] = 1'b0;
                ptr        = (g + 1) % REQ_NUM;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        check_eq("rst_res_val",   32'(res_val_o),   32'd0);
        check_eq("rst_res_id",    32'(res_id_o),    32'd0);
        check_eq("rst_res_count", 32'(res_count_o), 32'd0);
        check_eq("rst_busy",      32'(busy_o),      32'd0);
        pipe_q.delete();
        ptr = 0;
        for (int k = 0; k < REQ_NUM; k++) holding[k] = 1'b0;
        req_valid_i = '0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        rst_n_i     = 1'b0;
        arb_en_i    = 1'b0;
        req_data_i  = '0;
        req_valid_i = '0;
`ifdef BIT_COUNTER_ARB_STATS_EN
        stats_clr_i = 1'b0;
`endif
        ptr = 0;
        for (int k = 0; k < REQ_NUM; k++) begin
            holding[k]   = 1'b0;
            hold_data[k] = '0;
        end

        do_reset();
        run_cycles(40,  30,  4'b0100, 100);   // lone requester 2
        run_cycles(40,  100, 4'b1111, 100);   // continuous round robin
        run_cycles(10,  100, 4'b1111, 0);     // grant disabled, pipeline drains
        run_cycles(20,  100, 4'b1111, 100);   // resume from stored pointer
        run_cycles(300, 50,  4'b1111, 80);    // random traffic
        run_cycles(3,   100, 4'b1111, 100);
        do_reset();                           // words still in flight
        run_cycles(30,  60,  4'b1111, 100);
        run_cycles(10,  0,   4'b0000, 100);   // drain tail

`ifdef BIT_COUNTER_ARB_STATS_EN
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk_i);
            req_valid_i = 4'b0010;
            arb_en_i    = 1'b1;
        end
        @(negedge clk_i);
        check_eq("stats_sat", 32'(grant_cnt_o[16 +: 16]), 32'h0000FFFF);
        stats_clr_i = 1'b1;
        @(negedge clk_i);
        stats_clr_i = 1'b0;
        check_eq("stats_clr", 32'(grant_cnt_o[16 +: 16]), 32'd0);
        @(negedge clk_i);
        req_valid_i = '0;
        check_eq("stats_inc", 32'(grant_cnt_o[16 +: 16]), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
